hamming_stream_encoder: RTL

//  Transmit-side SECDED Hamming(8,4) encoder. It pairs with our 8-bit SECDED decoder.

---
 rtl/hamming_stream_encoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hamming_stream_encoder.sv
// ---------------------------------------------------------------------------------------------
// hamming_stream_encoder
//
// Transmit-side SECDED Hamming(8,4) encoder. Bytes arrive on a valid/ready input stream. Each
// byte is split into two nibbles, and each nibble is encoded into one 8-bit codeword. The two
// codewords go out on a registered valid/ready output stream, low nibble first.
//
// An optional per-byte error mask is XORed into the low-nibble codeword only. This lets the
// downstream decoder path be exercised on silicon.
//
// Codeword layout: {c_all, d3, d2, d1, c2, d0, c1, c0}
//   c0    = d0 ^ d1 ^ d3
//   c1    = d0 ^ d2 ^ d3
//   c2    = d1 ^ d2 ^ d3
//   c_all = even parity over bits [6:0]
//
// Parameters
//   INJECT_EN    1: in_err_mask is XORed into the low codeword; 0: the mask is ignored
//   CNT_W        width of the cw_count output-handshake counter
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     in_data / in_err_mask valid
//   in_ready     encoder can take a byte this cycle
//   in_data      byte to encode; [3:0] is sent first, [7:4] second
//   in_err_mask  error-injection mask, captured with the byte
//   out_valid    out_data holds a codeword
//   out_ready    sink accepts out_data this cycle
//   out_data     registered codeword
//   busy         state is not idle
//   cw_count     output handshakes completed, modulo 2^CNT_W
// ---------------------------------------------------------------------------------------------
module hamming_stream_encoder #(
  parameter int unsigned INJECT_EN = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [7:0]       in_err_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic [CNT_W-1:0] cw_count
);

  // -------------------------------------------------------------------------------------------
  // Nibble encoder
  // -------------------------------------------------------------------------------------------
  function automatic logic [7:0] enc_nibble(input logic [3:0] d);
    logic       c0;
    logic       c1;
    logic       c2;
    logic [6:0] cw7;
    c0  = d[0] ^ d[1] ^ d[3];
    c1  = d[0] ^ d[2] ^ d[3];
    c2  = d[1] ^ d[2] ^ d[3];
    cw7 = {d[3], d[2], d[1], c2, d[0], c1, c0};
    return {^cw7, cw7};
  endfunction

  // -------------------------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [3:0]        r_hi_nib;     // high nibble waiting behind the low codeword
  logic [7:0]        r_out_data;
  logic [CNT_W-1:0]  r_cw_count;

  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_valid;
  logic              w_out_xfer;
  logic              w_load_hi;
  logic [7:0]        w_mask_eff;
  logic [7:0]        w_lo_cw;

  // The mask is folded into the low codeword at capture time. Because of that, no mask
  // register is needed, whether or not injection is enabled.
  assign w_mask_eff = (INJECT_EN != 0) ? in_err_mask : 8'h00;
  assign w_lo_cw    = enc_nibble(in_data[3:0]) ^ w_mask_eff;

  // -------------------------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------------------------
  // out_ready -> in_ready is the only combinational path through this block. In HI, a
  // completing high handshake frees the output register for the next byte in the same cycle.
  assign w_in_ready  = rst_n & ((r_state == StIdle) | ((r_state == StHi) & out_ready));
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_out_valid = (r_state != StIdle);
  assign w_out_xfer  = w_out_valid & out_ready;
  assign w_load_hi   = (r_state == StLo) & out_ready;

  // -------------------------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_next = StLo;
        end
      end
      StLo: begin
        if (out_ready) begin
          w_state_next = StHi;
        end
      end
      StHi: begin
        if (out_ready) begin
          // Back-to-back: a waiting byte goes straight into LO, with no idle bubble.
          w_state_next = in_valid ? StLo : StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_nib   <= 4'h0;
      r_out_data <= 8'h00;
    end else if (w_in_xfer) begin
      r_hi_nib   <= in_data[7:4];
      r_out_data <= w_lo_cw;
    end else if (w_load_hi) begin
      // The high codeword is always sent clean.
      r_out_data <= enc_nibble(r_hi_nib);
    end
  end

  // Free-running handshake counter; it wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_count <= '0;
    end else if (w_out_xfer) begin
      r_cw_count <= r_cw_count + 1'b1;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_out_valid;
    out_data  = r_out_data;
    busy      = (r_state != StIdle);
    cw_count  = r_cw_count;
  end

endmodule
